// File: rtl/maze_pkg.sv
// Shared types and constants for the maze move controller and the renderer.
package maze_pkg;

   localparam int unsigned MAZE_W_DEF = 5;
   localparam int unsigned MAZE_H_DEF = 5;

   // Cardinal heading; the encoding matches angle = heading*64.
   typedef enum logic [1:0] {
      DIR_E = 2'd0,
      DIR_S = 2'd1,
      DIR_W = 2'd2,
      DIR_N = 2'd3
   } dir_e;

   // Button index doubles as the command code.
   typedef enum logic [1:0] {
      CMD_FWD   = 2'd0,
      CMD_BACK  = 2'd1,
      CMD_LEFT  = 2'd2,
      CMD_RIGHT = 2'd3
   } cmd_e;

   typedef enum logic [2:0] {
      ST_BOOT     = 3'd0,
      ST_IDLE     = 3'd1,
      ST_CHECK    = 3'd2,
      ST_UPDATE   = 3'd3,
      ST_REQ      = 3'd4,
      ST_WAIT_REL = 3'd5
   } state_e;

   // draw_mode codes understood by the renderer FSM.
   localparam logic [1:0] DM_IDLE   = 2'b00;
   localparam logic [1:0] DM_MOVE   = 2'b10;
   localparam logic [1:0] DM_ROTATE = 2'b11;

   // Heading arithmetic with 2-bit wrap.
   function automatic dir_e dir_add(input dir_e d, input logic [1:0] k);
      return dir_e'(2'(d + k));
   endfunction

endpackage

// File: rtl/maze_move_ctrl_if.sv
// Controller <-> board/renderer signal bundle.
interface maze_move_if
   import maze_pkg::*;
#(
   parameter int unsigned MAZE_W = MAZE_W_DEF,
   parameter int unsigned MAZE_H = MAZE_H_DEF
);
   localparam int unsigned HOR_BITS = (MAZE_H + 1) * MAZE_W;
   localparam int unsigned VER_BITS = MAZE_H * (MAZE_W + 1);

   logic [3:0]          btn_n;
   logic [HOR_BITS-1:0] hor_wall;
   logic [VER_BITS-1:0] ver_wall;
   logic                redraw_ack;
   logic [2:0]          pos_x;
   logic [2:0]          pos_y;
   logic [1:0]          heading;
   logic [7:0]          angle;
   logic [1:0]          draw_mode;
   logic                redraw_req;
   logic                bump;
   logic                at_goal;

   modport master (
      input  btn_n, hor_wall, ver_wall, redraw_ack,
      output pos_x, pos_y, heading, angle, draw_mode, redraw_req, bump, at_goal
   );

   modport slave (
      output btn_n, hor_wall, ver_wall, redraw_ack,
      input  pos_x, pos_y, heading, angle, draw_mode, redraw_req, bump, at_goal
   );
endinterface

// File: rtl/maze_move_ctrl_btn_debounce.sv
// One-bit button conditioner: 2-FF synchronizer, stability counter, rise pulse.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
)(
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o
);
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;

   // Count consecutive samples that disagree with the accepted level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchronizer and debounce state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
endmodule

// File: rtl/maze_move_ctrl.sv
// Maze player move controller: debounced buttons, wall check, position/heading,
// redraw req/ack handshake. Optional auto-repeat under MOVE_AUTOREPEAT_EN.
module maze_move_ctrl
   import maze_pkg::*;
#(
   parameter int unsigned MAZE_W          = MAZE_W_DEF,
   parameter int unsigned MAZE_H          = MAZE_H_DEF,
   parameter int unsigned START_X         = 0,
   parameter int unsigned START_Y         = 0,
   parameter int unsigned START_DIR       = 0,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
`ifdef MOVE_AUTOREPEAT_EN
   , parameter int unsigned REPEAT_CYCLES = 25_000_000
`endif
)(
   input  logic         clk,
   input  logic         rst,
   maze_move_if.master  mv
);
   localparam int unsigned HOR_BITS = (MAZE_H + 1) * MAZE_W;
   localparam int unsigned VER_BITS = MAZE_H * (MAZE_W + 1);
   localparam int unsigned HOR_AW   = $clog2(HOR_BITS);
   localparam int unsigned VER_AW   = $clog2(VER_BITS);
`ifdef MOVE_AUTOREPEAT_EN
   localparam int unsigned RPT_W    = 25;
`endif

   state_e     state_q, state_d;
   cmd_e       cmd_q, cmd_d;
   logic [2:0] pos_x_q, pos_x_d;
   logic [2:0] pos_y_q, pos_y_d;
   dir_e       heading_q, heading_d;
   logic [7:0] angle_q, angle_d;
   logic [1:0] mode_q, mode_d;
   logic       req_q, req_d;
   logic       bump_q, bump_d;
`ifdef MOVE_AUTOREPEAT_EN
   logic [RPT_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

   logic [3:0]  lvl, rise;
   cmd_e        rise_cmd_c;
   dir_e        move_dir_c;
   logic        blocked_c;
   logic [2:0]  next_x_c, next_y_c;
   int unsigned cx, cy, hor_idx, ver_idx;

   // Four button conditioners on the inverted (active-high) buttons.
   for (genvar i = 0; i < 4; i++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk     (clk),
         .rst     (rst),
         .btn_i   (~mv.btn_n[i]),
         .level_o (lvl[i]),
         .rise_o  (rise[i])
      );
   end

   // Lowest-index rising button wins.
   always_comb begin
      rise_cmd_c = CMD_RIGHT;
      if (rise[0])      rise_cmd_c = CMD_FWD;
      else if (rise[1]) rise_cmd_c = CMD_BACK;
      else if (rise[2]) rise_cmd_c = CMD_LEFT;
   end

   // Wall/border check and target cell for the captured move.
   always_comb begin
      move_dir_c = (cmd_q == CMD_BACK) ? dir_add(heading_q, 2'd2) : heading_q;
      cx         = 32'(pos_x_q);
      cy         = 32'(pos_y_q);
      hor_idx    = 0;
      ver_idx    = 0;
      blocked_c  = 1'b0;
      next_x_c   = pos_x_q;
      next_y_c   = pos_y_q;
      case (move_dir_c)
         DIR_E: begin
            ver_idx   = cy * (MAZE_W + 1) + cx + 1;
            blocked_c = (cx == MAZE_W - 1) || mv.ver_wall[VER_AW'(ver_idx)];
            next_x_c  = 3'(pos_x_q + 3'd1);
         end
         DIR_W: begin
            ver_idx   = cy * (MAZE_W + 1) + cx;
            blocked_c = (cx == 0) || mv.ver_wall[VER_AW'(ver_idx)];
            next_x_c  = 3'(pos_x_q - 3'd1);
         end
         DIR_S: begin
            hor_idx   = (cy + 1) * MAZE_W + cx;
            blocked_c = (cy == MAZE_H - 1) || mv.hor_wall[HOR_AW'(hor_idx)];
            next_y_c  = 3'(pos_y_q + 3'd1);
         end
         default: begin
            hor_idx   = cy * MAZE_W + cx;
            blocked_c = (cy == 0) || mv.hor_wall[HOR_AW'(hor_idx)];
            next_y_c  = 3'(pos_y_q - 3'd1);
         end
      endcase
   end

   // FSM next state and registered outputs.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      heading_d = heading_q;
      mode_d    = mode_q;
      req_d     = req_q;
      bump_d    = 1'b0;
`ifdef MOVE_AUTOREPEAT_EN
      rep_cnt_d = '0;
`endif
      case (state_q)
         ST_BOOT: begin
            req_d   = 1'b1;
            mode_d  = DM_MOVE;
            state_d = ST_REQ;
         end
         ST_IDLE: begin
            if (|rise) begin
               cmd_d   = rise_cmd_c;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (cmd_q == CMD_LEFT || cmd_q == CMD_RIGHT) begin
               heading_d = (cmd_q == CMD_LEFT) ? dir_add(heading_q, 2'd3)
                                               : dir_add(heading_q, 2'd1);
               req_d     = 1'b1;
               mode_d    = DM_ROTATE;
               state_d   = ST_UPDATE;
            end else if (blocked_c) begin
               bump_d  = 1'b1;
               state_d = ST_WAIT_REL;
            end else begin
               pos_x_d = next_x_c;
               pos_y_d = next_y_c;
               req_d   = 1'b1;
               mode_d  = DM_MOVE;
               state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (mv.redraw_ack) begin
               req_d   = 1'b0;
               mode_d  = DM_IDLE;
               state_d = ST_WAIT_REL;
            end
         end
         ST_WAIT_REL: begin
            if (lvl == 4'b0000) begin
               state_d = ST_IDLE;
            end
`ifdef MOVE_AUTOREPEAT_EN
            else if (lvl == 4'(4'b0001 << cmd_q)) begin
               if (rep_cnt_q == RPT_W'(REPEAT_CYCLES - 1)) begin
                  state_d = ST_CHECK;
               end else begin
                  rep_cnt_d = rep_cnt_q + RPT_W'(1);
               end
            end
`endif
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
      angle_d = {heading_d, 6'b000000};
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_BOOT;
         cmd_q     <= CMD_FWD;
         pos_x_q   <= 3'(START_X);
         pos_y_q   <= 3'(START_Y);
         heading_q <= dir_e'(2'(START_DIR));
         angle_q   <= {2'(START_DIR), 6'b000000};
         mode_q    <= DM_IDLE;
         req_q     <= 1'b0;
         bump_q    <= 1'b0;
`ifdef MOVE_AUTOREPEAT_EN
         rep_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         heading_q <= heading_d;
         angle_q   <= angle_d;
         mode_q    <= mode_d;
         req_q     <= req_d;
         bump_q    <= bump_d;
`ifdef MOVE_AUTOREPEAT_EN
         rep_cnt_q <= rep_cnt_d;
`endif
      end
   end

   assign mv.pos_x      = pos_x_q;
   assign mv.pos_y      = pos_y_q;
   assign mv.heading    = heading_q;
   assign mv.angle      = angle_q;
   assign mv.draw_mode  = mode_q;
   assign mv.redraw_req = req_q;
   assign mv.bump       = bump_q;
   assign mv.at_goal    = (pos_x_q == 3'(MAZE_W - 1)) && (pos_y_q == 3'(MAZE_H - 1));
endmodule
